gift_sbox_layer_ctrl: RTL and testbench
=======================================

Name: gift_sbox_layer_ctrl

Overview:
- Sequences one full GIFT S-box layer (NIBBLES nibbles, 3-share masked) through a single shared, free-running 3-share second-order masked S-box pipeline, one nibble per cycle.
- Fetches 8 bits of fresh randomness per nibble over a valid/ready handshake and tracks in-flight nibbles with a valid/index shift register.
- Reassembles the output shares and signals completion.
- Sits between the round datapath (state shares) and the S-box instance.

Parameters:
- NIBBLES, 16, nibbles per layer (16 = GIFT-64, 32 = GIFT-128); state width W = 4*NIBBLES.
- SBOX_LAT, 4, cycles from the S-box share inputs to the share outputs. Must equal the instance's latency at integration.

Ports:
- clk  in  1  clock, all flops rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- st1, st2, st3  in  W  input state shares, latched on accepted start
- rnd  in  8  fresh randomness word
- rnd_valid  in  1  rnd available
- rnd_ready  out  1  controller consumes rnd this cycle
- sb_in1, sb_in2, sb_in3  out  4  share nibble to S-box
- sb_r  out  8  randomness to S-box
- sb_out1, sb_out2, sb_out3  in  4  share nibble from S-box
- res1, res2, res3  out  W  output state shares
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, layer complete

Behaviour:
- Reset (async, any time including mid-layer):
  - State returns to IDLE.
  - busy, done, rnd_ready, sb_in*, sb_r, res* and all tracking flops go to 0.
  - No partial result survives.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 latches st1..3, clears feed index and capture counter, and moves to FEED.
  - start in any other state is ignored.
- FEED:
  - rnd_ready=1.
  - When rnd_valid=1, nibble i = feed index is injected: sb_in1..3 = latched share bits [4i+3:4i], sb_r = rnd. The feed index then increments.
  - When rnd_valid=0, it is a bubble: sb_in* = 0 and sb_r = 0.
  - sb_in*/sb_r are combinational from the latched shares, index and rnd.
  - Injection order is nibble 0 (bits [3:0]) first, ascending.
  - After the injection of nibble NIBBLES-1, go to DRAIN.
- Tracking:
  - A SBOX_LAT-deep shift register carries {valid, index}. It shifts every cycle because the S-box has no enable.
  - When the tail is valid, sb_out1..3 are written into res1..3 bits [4*idx+3:4*idx] and the capture counter increments.
- DRAIN:
  - rnd_ready=0 and sb_in*/sb_r = 0.
  - Stay until the capture counter reaches NIBBLES, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- res1..3 are updated only by captures. They hold the last layer's result until the next layer's captures overwrite them nibble by nibble.
- Timing, no stalls, start accepted at edge k:
  - Nibble i is driven in cycle k+1+i.
  - It is captured at the end of cycle k+1+i+SBOX_LAT.
  - done is high in cycle k+NIBBLES+SBOX_LAT+1. With defaults that is 21 cycles after the start cycle.
  - Each rnd_valid-low cycle during FEED delays done by 1.
- Randomness:
  - Exactly NIBBLES handshakes per layer.
  - rnd is never reused and never consumed outside FEED.
- Masking: unmasked values are never combined. Share k of the state feeds only sb_ink and resk.
- Counter widths: feed index and capture counter are clog2(NIBBLES)+1 bits. Neither wraps within a layer.

Test Plan:
- No-stall layer: NIBBLES=16, SBOX_LAT=4, random shares and rnd_valid held 1 -> done in cycle start+21, exactly 16 rnd handshakes, and XOR of res shares equals GIFT S-box applied to XOR of input shares, per nibble. Use a behavioural masked S-box model with latency 4.
- Randomness stalls: rnd_valid low on nibbles 3, 7 and 15 for 2 cycles each -> done at start+27, sb_in*=0 during each bubble, result correct, captures in index order.
- Ordering: st1=0x0123456789ABCDEF, st2=st3=0, model S-box = identity -> res1=0x0123456789ABCDEF, res2=res3=0. Nibble 0 (0xF) is driven first.
- Start while busy: second start pulse mid-FEED -> ignored, single done, rnd handshake count 16.
- Async reset mid-FEED after nibble 5: rst_n low for half a cycle -> all outputs 0 immediately. A new start afterwards completes correctly in 21 cycles.
- Back-to-back layers: start asserted in the cycle after done -> second layer accepted, and res holds layer-1 values until its nibbles are overwritten.

Source files
------------

// File: rtl/gift_sbox_layer_ctrl_if.sv
// Purpose: bundles the round-datapath, randomness and S-box share buses of the
//          GIFT S-box layer controller.
// Signals:
//   start          begin a layer (sampled only while the controller is idle)
//   st1..st3       input state shares, W = 4*NIBBLES bits each
//   rnd/rnd_valid  fresh 8-bit randomness offered by the RNG
//   rnd_ready      controller consumes rnd this cycle
//   sb_in1..3      share nibble presented to the masked S-box
//   sb_r           randomness presented to the masked S-box
//   sb_out1..3     share nibble returned by the masked S-box
//   res1..res3     output state shares
//   busy/done      layer in progress / one-cycle completion pulse
// Modports: slave = controller, master = surrounding datapath/RNG/S-box.
interface gift_sbox_layer_ctrl_if #(
  parameter int unsigned NIBBLES = 16
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] st1;
  logic [W-1:0] st2;
  logic [W-1:0] st3;
  logic [7:0]   rnd;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [3:0]   sb_in1;
  logic [3:0]   sb_in2;
  logic [3:0]   sb_in3;
  logic [7:0]   sb_r;
  logic [3:0]   sb_out1;
  logic [3:0]   sb_out2;
  logic [3:0]   sb_out3;
  logic [W-1:0] res1;
  logic [W-1:0] res2;
  logic [W-1:0] res3;
  logic         busy;
  logic         done;

  modport slave (
    input  start, st1, st2, st3, rnd, rnd_valid, sb_out1, sb_out2, sb_out3,
    output rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, res1, res2, res3, busy, done
  );

  modport master (
    output start, st1, st2, st3, rnd, rnd_valid, sb_out1, sb_out2, sb_out3,
    input  rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, res1, res2, res3, busy, done
  );
endinterface

// File: rtl/gift_sbox_layer_ctrl.sv
// Purpose: sequences one GIFT S-box layer (NIBBLES nibbles, 3 shares) through a
//          single free-running masked S-box pipeline of latency SBOX_LAT, one
//          nibble per accepted randomness word, and reassembles the result.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    controller side (slave) of gift_sbox_layer_ctrl_if
// Shares are never recombined here: share k only ever feeds sb_ink and resk.
module gift_sbox_layer_ctrl #(
  parameter int unsigned NIBBLES  = 16,
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gift_sbox_layer_ctrl_if.slave bus
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES) + 1;
  localparam int unsigned XW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned BW = XW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       r_state;
  logic [W-1:0]                 r_st1;
  logic [W-1:0]                 r_st2;
  logic [W-1:0]                 r_st3;
  logic [W-1:0]                 r_res1;
  logic [W-1:0]                 r_res2;
  logic [W-1:0]                 r_res3;
  logic [CW-1:0]                r_feed_idx;
  logic [CW-1:0]                r_cap_cnt;
  logic [SBOX_LAT-1:0]          r_pipe_vld;
  logic [SBOX_LAT-1:0][XW-1:0]  r_pipe_idx;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_rnd_ready;

  logic                         w_inject;
  logic [XW-1:0]                w_feed_nib;
  logic [BW-1:0]                w_feed_lo;
  logic                         w_cap;
  logic [XW-1:0]                w_cap_nib;
  logic [BW-1:0]                w_cap_lo;
  logic [CW-1:0]                w_cap_cnt_nxt;

  // A nibble enters the S-box only on a completed randomness handshake.
  assign w_inject   = r_rnd_ready && bus.rnd_valid;
  assign w_feed_nib = r_feed_idx[XW-1:0];
  assign w_feed_lo  = {w_feed_nib, 2'b00};

  // Pipeline tail marks the cycle in which sb_out* belongs to a real nibble.
  assign w_cap         = r_pipe_vld[SBOX_LAT-1];
  assign w_cap_nib     = r_pipe_idx[SBOX_LAT-1];
  assign w_cap_lo      = {w_cap_nib, 2'b00};
  assign w_cap_cnt_nxt = r_cap_cnt + CW'(w_cap);

  // S-box drive: combinational so the nibble and its randomness meet the
  // S-box in the handshake cycle; zero during bubbles and outside FEED.
  assign bus.sb_in1 = w_inject ? r_st1[w_feed_lo +: 4] : 4'h0;
  assign bus.sb_in2 = w_inject ? r_st2[w_feed_lo +: 4] : 4'h0;
  assign bus.sb_in3 = w_inject ? r_st3[w_feed_lo +: 4] : 4'h0;
  assign bus.sb_r   = w_inject ? bus.rnd : 8'h00;

  assign bus.rnd_ready = r_rnd_ready;
  assign bus.res1      = r_res1;
  assign bus.res2      = r_res2;
  assign bus.res3      = r_res3;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Control FSM, in-flight tracking and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_st1       <= '0;
      r_st2       <= '0;
      r_st3       <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_res3      <= '0;
      r_feed_idx  <= '0;
      r_cap_cnt   <= '0;
      r_pipe_vld  <= '0;
      r_pipe_idx  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rnd_ready <= 1'b0;
    end else begin
      // The S-box has no enable, so the tracker shifts every cycle.
      r_pipe_vld[0] <= w_inject;
      r_pipe_idx[0] <= w_feed_nib;
      for (int i = 1; i < int'(SBOX_LAT); i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end

      if (w_cap) begin
        r_res1[w_cap_lo +: 4] <= bus.sb_out1;
        r_res2[w_cap_lo +: 4] <= bus.sb_out2;
        r_res3[w_cap_lo +: 4] <= bus.sb_out3;
        r_cap_cnt             <= w_cap_cnt_nxt;
      end

      r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_st1       <= bus.st1;
            r_st2       <= bus.st2;
            r_st3       <= bus.st3;
            r_feed_idx  <= '0;
            r_cap_cnt   <= '0;
            r_busy      <= 1'b1;
            r_rnd_ready <= 1'b1;
            r_state     <= FEED;
          end
        end
        FEED: begin
          if (w_inject) begin
            r_feed_idx <= r_feed_idx + CW'(1);
            if (r_feed_idx == CW'(NIBBLES - 1)) begin
              r_rnd_ready <= 1'b0;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Look at the post-capture count so done lands right after the last capture.
          if (w_cap_cnt_nxt == CW'(NIBBLES)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gift_sbox_layer_ctrl.sv
// Purpose: scoreboard bench for gift_sbox_layer_ctrl with a behavioural masked
//          GIFT S-box (latency 4) and a layer-level reference model.
module tb_gift_sbox_layer_ctrl;

  localparam int NIB = 16;
  localparam int LAT = 4;
  localparam int W   = 4 * NIB;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   hs_cnt;
  bit   sb_ident;
  int   stall_n[NIB];
  logic [W-1:0] prev_x;

  typedef struct {
    int           s;
    int           inj[NIB];
    int           done;
    logic [W-1:0] st1;
    logic [W-1:0] st2;
    logic [W-1:0] st3;
    logic [W-1:0] exp_x;
    bit           ident;
    int           hs_base;
  } layer_t;

  layer_t q[$];

  gift_sbox_layer_ctrl_if #(.NIBBLES(NIB)) bus ();

  gift_sbox_layer_ctrl #(.NIBBLES(NIB), .SBOX_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_cnt <= 0;
    else if (bus.rnd_valid && bus.rnd_ready) hs_cnt <= hs_cnt + 1;
  end

  function automatic logic [3:0] gift_s(input logic [3:0] x);
    logic [3:0] t[16];
    t = '{4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
          4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE};
    return t[x];
  endfunction

  // Behavioural masked S-box: LAT-cycle delay line, then re-share the S-box value.
  logic [3:0] p1[LAT];
  logic [3:0] p2[LAT];
  logic [3:0] p3[LAT];
  logic [7:0] pr[LAT];
  logic [3:0] m_o1, m_o2, m_o3;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      p1[i] = 4'h0; p2[i] = 4'h0; p3[i] = 4'h0; pr[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    p1[0] <= bus.sb_in1; p2[0] <= bus.sb_in2; p3[0] <= bus.sb_in3; pr[0] <= bus.sb_r;
    for (int i = 1; i < LAT; i++) begin
      p1[i] <= p1[i-1]; p2[i] <= p2[i-1]; p3[i] <= p3[i-1]; pr[i] <= pr[i-1];
    end
  end

  always_comb begin
    m_o1 = p1[LAT-1];
    m_o2 = p2[LAT-1];
    m_o3 = p3[LAT-1];
    if (!sb_ident) begin
      m_o2 = p2[LAT-1] ^ pr[LAT-1][3:0];
      m_o3 = p3[LAT-1] ^ pr[LAT-1][7:4];
      m_o1 = gift_s(p1[LAT-1] ^ p2[LAT-1] ^ p3[LAT-1]) ^ m_o2 ^ m_o3;
    end
  end

  assign bus.sb_out1 = m_o1;
  assign bus.sb_out2 = m_o2;
  assign bus.sb_out3 = m_o3;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_ready"}, bus.rnd_ready, 0);
    chk({tag, "_sbin"},  {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_r}, 0);
    chk({tag, "_res1"},  bus.res1, 0);
    chk({tag, "_res2"},  bus.res2, 0);
    chk({tag, "_res3"},  bus.res3, 0);
  endtask

  // Monitor: compares every cycle against the oldest outstanding layer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() == 0) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_ready", bus.rnd_ready, 0);
        chk("idle_sbin", {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_r}, 0);
        chk("idle_res_xor", bus.res1 ^ bus.res2 ^ bus.res3, prev_x);
      end else begin
        layer_t     cur;
        int         inj;
        logic [W-1:0] ex;
        logic [19:0]  exp_sb;
        bit         exp_done;
        cur = q[0];
        inj = -1;
        for (int i = 0; i < NIB; i++) if (cur.inj[i] == cyc) inj = i;
        exp_sb = 20'h0;
        if (inj >= 0)
          exp_sb = {cur.st1[4*inj +: 4], cur.st2[4*inj +: 4], cur.st3[4*inj +: 4], bus.rnd};
        for (int i = 0; i < NIB; i++)
          ex[4*i +: 4] = (cyc > cur.inj[i] + LAT) ? cur.exp_x[4*i +: 4] : prev_x[4*i +: 4];
        exp_done = (cyc == cur.done);
        chk("rnd_ready", bus.rnd_ready, (cyc > cur.s && cyc <= cur.inj[NIB-1]) ? 1 : 0);
        chk("sb_drive", {bus.sb_in1, bus.sb_in2, bus.sb_in3, bus.sb_r}, exp_sb);
        chk("busy", bus.busy, (cyc > cur.s && cyc < cur.done) ? 1 : 0);
        chk("done", bus.done, exp_done ? 1 : 0);
        chk("res_xor", bus.res1 ^ bus.res2 ^ bus.res3, ex);
        if (exp_done) begin
          chk("hs_count", hs_cnt - cur.hs_base, NIB);
          if (cur.ident) begin
            chk("ident_res1", bus.res1, cur.st1);
            chk("ident_res2", bus.res2, cur.st2);
            chk("ident_res3", bus.res3, cur.st3);
          end
          prev_x = cur.exp_x;
          cur = q.pop_front();
        end
      end
    end
  end

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.rnd_valid = 1'($urandom);
      bus.rnd       = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.rnd_valid = 1'b0;
    #2;
    check_outputs_zero("async_rst");
    q.delete();
    prev_x = '0;
    #3;
    rst_n = 1'b1;
  endtask

  // Issues one layer; xstart = feed step for a stray start pulse, abort_nib =
  // nibble after whose injection reset is pulsed (-1 for none).
  task automatic run_layer(input bit ident, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input int xstart, input int abort_nib);
    layer_t rec;
    bit     sched[$];
    logic [3:0] x;
    @(posedge clk); #1;
    sb_ident      = ident;
    bus.start     = 1'b1;
    bus.st1       = a;
    bus.st2       = b;
    bus.st3       = c;
    bus.rnd_valid = 1'($urandom);
    bus.rnd       = 8'($urandom);
    rec.s     = cyc;
    rec.st1   = a;
    rec.st2   = b;
    rec.st3   = c;
    rec.ident = ident;
    rec.hs_base = hs_cnt;
    sched.delete();
    for (int i = 0; i < NIB; i++) begin
      repeat (stall_n[i]) sched.push_back(1'b0);
      rec.inj[i] = rec.s + 1 + sched.size();
      sched.push_back(1'b1);
      x = a[4*i +: 4] ^ b[4*i +: 4] ^ c[4*i +: 4];
      rec.exp_x[4*i +: 4] = ident ? x : gift_s(x);
    end
    rec.done = rec.inj[NIB-1] + LAT + 1;
    q.push_back(rec);
    for (int t = 0; t < sched.size(); t++) begin
      @(posedge clk); #1;
      if (abort_nib >= 0 && cyc == rec.inj[abort_nib] + 1) begin
        do_reset();
        return;
      end
      bus.start = (t == xstart);
      if (t == xstart) begin
        bus.st1 = {$urandom, $urandom};
        bus.st2 = {$urandom, $urandom};
        bus.st3 = {$urandom, $urandom};
      end
      bus.rnd_valid = sched[t];
      bus.rnd       = 8'($urandom);
    end
    while (cyc < rec.done && cyc < rec.s + 200) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.rnd_valid = 1'($urandom);
      bus.rnd       = 8'($urandom);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_chk = 0; n_err = 0; prev_x = '0; sb_ident = 1'b0;
    for (int i = 0; i < NIB; i++) stall_n[i] = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.rnd_valid = 1'b0; bus.rnd = 8'h00;
    bus.st1 = '0; bus.st2 = '0; bus.st3 = '0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    #1;
    rst_n = 1'b1;
    drive_idle(2);

    // Ordering with identity S-box: nibble 0 (0xF) goes first.
    run_layer(1'b1, 64'h0123456789ABCDEF, '0, '0, -1, -1);
    drive_idle(2);

    // No-stall random layers.
    repeat (2) begin
      run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, -1);
      drive_idle(1);
    end

    // Two-cycle randomness stalls on nibbles 3, 7 and 15.
    stall_n[3] = 2; stall_n[7] = 2; stall_n[15] = 2;
    run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, -1);
    for (int i = 0; i < NIB; i++) stall_n[i] = 0;
    drive_idle(2);

    // Stray start pulse mid-FEED must be ignored.
    run_layer(1'b0, rand_w(), rand_w(), rand_w(), 6, -1);
    drive_idle(2);

    // Async reset after nibble 5, then a clean layer.
    run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, 5);
    run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, -1);

    // Back-to-back layers: second start in the cycle right after done.
    run_layer(1'b1, rand_w(), rand_w(), rand_w(), -1, -1);
    run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, -1);
    drive_idle(1);

    // Random stall patterns.
    repeat (4) begin
      for (int i = 0; i < NIB; i++)
        stall_n[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_layer(1'b0, rand_w(), rand_w(), rand_w(), -1, -1);
      drive_idle(int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < NIB; i++) stall_n[i] = 0;

    drive_idle(6);
    chk("pending_layers", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
